mv_collector: RTL



---
 rtl/me_pkg.sv | 40 ++++
 rtl/mv_fifo.sv | 67 ++++++
 rtl/mv_collector.sv | 127 ++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// me_pkg -- shared definitions for the motion-vector collector.
//   Field widths, result-entry layout (as a packed struct plus explicit bit
//   offsets), FSM state encodings and the unsigned-to-signed MV mapping.
package me_pkg;

  localparam int MV_W    = 5;   // motion-vector component width
  localparam int SAD_W   = 14;  // per-block minimum SAD width
  localparam int FSAD_W  = 21;  // per-frame SAD accumulator width
  localparam int BIDX_W  = 7;   // block index width (up to 128 blocks)

  localparam int ENTRY_W = BIDX_W + 2 * MV_W + SAD_W;  // 31

  // Bit offsets of each field inside a result entry.
  localparam int SAD_LSB  = 0;
  localparam int MVY_LSB  = SAD_LSB + SAD_W;   // 14
  localparam int MVX_LSB  = MVY_LSB + MV_W;    // 19
  localparam int BIDX_LSB = MVX_LSB + MV_W;    // 24

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Declaration order matches the offsets above (MSB first).
  typedef struct packed {
    logic [BIDX_W-1:0] blk_idx;
    logic [MV_W-1:0]   mv_x;
    logic [MV_W-1:0]   mv_y;
    logic [SAD_W-1:0]  sad;
  } mv_entry_t;

  // Search-window position 0..31 becomes a two's-complement offset -16..+15:
  // subtracting 16 from a 5-bit value is the same as flipping its MSB.
  function automatic logic [MV_W-1:0] to_signed_mv(input logic [MV_W-1:0] pos);
    return {~pos[MV_W-1], pos[MV_W-2:0]};
  endfunction

endpackage

// File: rtl/mv_fifo.sv
// mv_fifo -- synchronous first-word fall-through FIFO.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: write request and data; accepted when not full, or when
//                  full but a pop happens in the same cycle
//   pop_i        : read request; ignored while empty
//   data_o       : head entry, valid whenever valid_o=1
//   valid_o      : FIFO not empty
//   full_o       : FIFO holds DEPTH entries
module mv_fifo #(
  parameter int DEPTH = 8,   // power of two, at least 2
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic empty;
  logic do_pop;
  logic do_push;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty;
    // A full FIFO still takes a write when a slot frees in the same cycle.
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = wptr_q + (AW + 1)'(do_push);
    rptr_d  = rptr_q + (AW + 1)'(do_pop);
    valid_o = !empty;
    data_o  = mem_q[rptr_q[AW-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is defined
  // solely by the pointers, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mv_collector.sv
// mv_collector -- gathers per-macroblock motion-estimation results for one
// frame into a FIFO of tagged motion vectors and accumulates the frame SAD.
//   clk, rst        : clock, synchronous active-high reset
//   en_i            : frame-start pulse (honoured only in IDLE)
//   data_valid      : one strobe per macroblock result (honoured only in COLLECT)
//   MSAD            : block minimum SAD
//   MSAD_column/row : best search position 0..31
//   mv_valid_o      : FIFO head valid
//   mv_ready_i      : consumer accepts the head
//   mv_data_o       : {blk_idx, mv_x, mv_y, sad}
//   frame_sad_o     : running MSAD sum for the current frame
//   frame_done_o    : one-cycle pulse once the frame has fully drained
//   overflow_o      : sticky, set when a result is dropped on a full FIFO
module mv_collector
  import me_pkg::*;
#(
  parameter int DEPTH            = 8,
  parameter int BLOCKS_PER_FRAME = 99
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                data_valid,
  input  logic [SAD_W-1:0]    MSAD,
  input  logic [MV_W-1:0]     MSAD_column,
  input  logic [MV_W-1:0]     MSAD_row,
  output logic                mv_valid_o,
  input  logic                mv_ready_i,
  output logic [ENTRY_W-1:0]  mv_data_o,
  output logic [FSAD_W-1:0]   frame_sad_o,
  output logic                frame_done_o,
  output logic                overflow_o
);

  localparam logic [BIDX_W-1:0] LAST_BLK = BIDX_W'(BLOCKS_PER_FRAME - 1);

  state_e              state_q, state_d;
  logic [BIDX_W-1:0]   cnt_q, cnt_d;
  logic [FSAD_W-1:0]   fsad_q, fsad_d;
  logic                ovf_q, ovf_d;

  logic                capture;
  logic                pop;
  logic                fifo_valid;
  logic                fifo_full;
  mv_entry_t           entry;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    capture       = (state_q == ST_COLLECT) && data_valid;
    pop           = fifo_valid && mv_ready_i;

    entry.blk_idx = cnt_q;
    entry.mv_x    = to_signed_mv(MSAD_column);
    entry.mv_y    = to_signed_mv(MSAD_row);
    entry.sad     = MSAD;

    state_d = state_q;
    cnt_d   = cnt_q;
    fsad_d  = fsad_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
          fsad_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (data_valid) begin
          // Counter and frame SAD advance even if the entry gets dropped.
          cnt_d  = cnt_q + 1'b1;
          fsad_d = fsad_q + FSAD_W'(MSAD);
          if (fifo_full && !pop) ovf_d = 1'b1;
          if (cnt_q == LAST_BLK) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!fifo_valid) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fsad_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fsad_q  <= fsad_d;
      ovf_q   <= ovf_d;
    end
  end

  // The FIFO itself decides whether a push on a full queue is accepted
  // (only alongside a pop); the overflow flag above mirrors that rule.
  mv_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .data_i  (entry),
    .pop_i   (mv_ready_i),
    .data_o  (mv_data_o),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign mv_valid_o   = fifo_valid;
  assign frame_sad_o  = fsad_q;
  assign frame_done_o = (state_q == ST_DONE);
  assign overflow_o   = ovf_q;

endmodule
